// File: rtl/addsub_serial_param_if.sv
// Handshake and data bundle for the digit-serial add/sub unit.
// The master drives operands and out_ready; the slave returns the result and flags.
interface addsub_serial_param_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, op, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );
endinterface

// File: rtl/addsub_serial_param.sv
// Digit-serial signed add/subtract: DIGIT bits per cycle over WIDTH/DIGIT cycles,
// with valid/ready handshake, overflow/zero flags and optional saturation.
module addsub_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2,
    parameter int SAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    addsub_serial_param_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic               carry_q;
    logic               op_q;
    logic               a_sign_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   sum_q;
    logic               c_out_q;
    logic               ovf_q;
    logic               zero_q;

    logic [DIGIT-1:0]       digit_d;
    logic                   carry_d;
    logic                   carry_msb_d;
    logic [WIDTH+DIGIT-1:0] acc_cat_d;
    logic [WIDTH+DIGIT-1:0] a_cat_d;
    logic [WIDTH+DIGIT-1:0] b_cat_d;
    logic [WIDTH-1:0]       acc_d;
    logic [WIDTH-1:0]       a_d;
    logic [WIDTH-1:0]       b_d;
    logic [WIDTH-1:0]       final_d;
    logic                   ovf_d;

    // One digit of ripple carry; carry_msb_d is the carry into the top bit of this digit,
    // which on the last digit is the carry into the operand MSB.
    always_comb begin
        carry_d     = carry_q;
        carry_msb_d = carry_q;
        digit_d     = '0;
        for (int i = 0; i < DIGIT; i++) begin
            carry_msb_d = carry_d;
            digit_d[i]  = a_q[i] ^ b_q[i] ^ carry_d;
            carry_d     = (a_q[i] & b_q[i]) | (carry_d & (a_q[i] ^ b_q[i]));
        end
        acc_cat_d = {digit_d, acc_q};
        a_cat_d   = {{DIGIT{1'b0}}, a_q};
        b_cat_d   = {{DIGIT{1'b0}}, b_q};
        acc_d     = acc_cat_d[WIDTH+DIGIT-1 -: WIDTH];
        a_d       = a_cat_d[WIDTH+DIGIT-1 -: WIDTH];
        b_d       = b_cat_d[WIDTH+DIGIT-1 -: WIDTH];
        ovf_d     = carry_d ^ carry_msb_d;
        if ((SAT != 0) && ovf_d) begin
            if (a_sign_q) begin
                final_d = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                final_d = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            final_d = acc_d;
        end
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            op_q        <= 1'b0;
            a_sign_q    <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is a + ~b + ~c_in, so invert b and the seed here.
                        a_q        <= bus.a;
                        b_q        <= bus.op ? ~bus.b : bus.b;
                        carry_q    <= bus.op ? ~bus.c_in : bus.c_in;
                        op_q       <= bus.op;
                        a_sign_q   <= bus.a[WIDTH-1];
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    carry_q <= carry_d;
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        sum_q       <= final_d;
                        c_out_q     <= op_q ? ~carry_d : carry_d;
                        ovf_q       <= ovf_d;
                        zero_q      <= (final_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
